// File: rtl/jk_bank_writer.sv
// Drives a bank of master-slave JK flip-flops to a target word: excitation, clock pulse, readback, retry.
// Optional hard clear before loading is enabled by defining JK_HARD_CLEAR_EN (adds clear_req port).
module jk_bank_writer #(
    parameter int WIDTH        = 8,
    parameter int PULSE_CYCLES = 2,
    parameter int MAX_RETRY    = 3
) (
    input  logic             clk,
    input  logic             cl,
    input  logic             start,
`ifdef JK_HARD_CLEAR_EN
    input  logic             clear_req,
`endif
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             ff_clk,
    output logic             ff_cl_n,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [CW-1:0] CNT_LAST  = CW'(PULSE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef JK_HARD_CLEAR_EN
        S_CLEAR,
`endif
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [RW-1:0]     retry, retry_nxt;
    logic [WIDTH-1:0]  tgt, tgt_nxt;
    logic [WIDTH-1:0]  j_nxt, k_nxt;
    logic              err_nxt;

    // JK excitation without the toggle case: set where Q must rise, reset where it must fall.
    function automatic logic [WIDTH-1:0] set_mask(input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] q);
        return t & ~q;
    endfunction

    function automatic logic [WIDTH-1:0] reset_mask(input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] q);
        return ~t & q;
    endfunction

    function automatic logic is_busy(input state_t s);
        return (s != S_IDLE) && (s != S_DONE) && (s != S_ERR);
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry;
        tgt_nxt   = tgt;
        err_nxt   = err;
        j_nxt     = j_out;
        k_nxt     = k_out;

        case (state)
            S_IDLE: begin
                if (start) begin
                    tgt_nxt   = target;
                    err_nxt   = 1'b0;
                    retry_nxt = '0;
                    cnt_nxt   = '0;
                    state_nxt = S_SETUP;
                    j_nxt     = set_mask(target, q_in);
                    k_nxt     = reset_mask(target, q_in);
`ifdef JK_HARD_CLEAR_EN
                    if (clear_req) begin
                        state_nxt = S_CLEAR;
                        j_nxt     = '0;
                        k_nxt     = '0;
                    end
`endif
                end
            end
`ifdef JK_HARD_CLEAR_EN
            S_CLEAR: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_SETUP;
                    j_nxt     = set_mask(tgt, q_in);
                    k_nxt     = reset_mask(tgt, q_in);
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`endif
            S_SETUP: begin
                cnt_nxt   = '0;
                state_nxt = S_HIGH;
            end
            S_HIGH: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_LOW;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_LOW: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_CHECK;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_CHECK: begin
                if (q_in == tgt) begin
                    state_nxt = S_DONE;
                end else if (retry < RETRY_MAX) begin
                    // Retry re-derives J/K from whatever the bank actually holds now.
                    retry_nxt = retry + 1'b1;
                    state_nxt = S_SETUP;
                    j_nxt     = set_mask(tgt, q_in);
                    k_nxt     = reset_mask(tgt, q_in);
                end else begin
                    state_nxt = S_ERR;
                    err_nxt   = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        if (!is_busy(state_nxt)) begin
            j_nxt = '0;
            k_nxt = '0;
        end
    end

    // All bank-facing outputs are registered so ff_clk is glitch-free.
    always_ff @(posedge clk) begin
        if (cl) begin
            state  <= S_IDLE;
            cnt    <= '0;
            retry  <= '0;
            tgt    <= '0;
            j_out  <= '0;
            k_out  <= '0;
            ff_clk <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            retry  <= retry_nxt;
            tgt    <= tgt_nxt;
            j_out  <= j_nxt;
            k_out  <= k_nxt;
            ff_clk <= (state_nxt == S_HIGH);
            busy   <= is_busy(state_nxt);
            done   <= (state_nxt == S_DONE);
            err    <= err_nxt;
        end
    end

`ifdef JK_HARD_CLEAR_EN
    always_ff @(posedge clk) begin
        if (cl) begin
            ff_cl_n <= 1'b1;
        end else begin
            ff_cl_n <= (state_nxt != S_CLEAR);
        end
    end
`else
    assign ff_cl_n = 1'b1;
`endif

endmodule
